// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory, IF/ID and redirect signal bundle  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_write;
  logic [31:0] PC_out;
  logic [31:0] IR_out;
  logic        out_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, PC_out, IR_out, out_valid, fetch_fault,
    input  imem_rvalid, imem_rdata, id_write, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, PC_out, IR_out, out_valid, fetch_fault,
    output imem_rvalid, imem_rdata, id_write, redirect, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC, variable-latency imem fetch, IF/ID output FIFO.      |
// | Optional macro FETCH_ALIGN_CHECK_EN: sticky fault on misaligned jump. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master bus
);
  localparam int                 c_PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [c_PTR_W:0]   c_DEPTH   = (c_PTR_W + 1)'(BUF_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DROP = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        r_pc_req;
  logic [31:0]        r_pc_mem [BUF_DEPTH];
  logic [31:0]        r_ir_mem [BUF_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [31:0]        w_target;
  logic               w_fault;
  logic               w_nonempty;
  logic               w_space;
  logic               w_req;
  logic               w_push;
  logic               w_pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_fault <= 1'b0;
    else if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00))
      r_fault <= 1'b1;
  end

  assign w_target = bus.redirect_pc;
  assign w_fault  = r_fault;
`else
  logic w_unused_align;

  assign w_unused_align = ^bus.redirect_pc[1:0];
  assign w_target       = {bus.redirect_pc[31:2], 2'b00};
  assign w_fault        = 1'b0;
`endif

  // A pop in the same cycle never frees space for a new request.
  assign w_nonempty = (r_count != '0);
  assign w_space    = (r_count < c_DEPTH);
  assign w_req      = !rst && (r_state == c_IDLE) && w_space && !bus.redirect && !w_fault;
  assign w_push     = (r_state == c_WAIT) && bus.imem_rvalid && !bus.redirect;
  assign w_pop      = w_nonempty && bus.id_write && !bus.redirect;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_req) w_state_nxt = c_WAIT;
      c_WAIT: begin
        if (bus.imem_rvalid)
          w_state_nxt = c_IDLE;
        else if (bus.redirect)
          w_state_nxt = c_DROP;
      end
      c_DROP:  if (bus.imem_rvalid) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_pc     <= RESET_PC;
      r_pc_req <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.redirect) begin
        r_pc     <= w_target;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_req) begin
          r_pc_req <= r_pc;
          r_pc     <= r_pc + 32'd4;
        end
        if (w_push)
          r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        if (w_push && !w_pop)
          r_count <= r_count + c_CNT_ONE;
        else if (w_pop && !w_push)
          r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Storage needs no reset: the head is only visible while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr] <= r_pc_req + 32'd4;
      r_ir_mem[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.out_valid   = w_nonempty;
  assign bus.PC_out      = w_nonempty ? r_pc_mem[r_rd_ptr] : 32'h0;
  assign bus.IR_out      = w_nonempty ? r_ir_mem[r_rd_ptr] : 32'h0;
  assign bus.fetch_fault = w_fault;

endmodule
`default_nettype wire
